// File: rtl/thrust_conditioner.sv
// Thrust conditioner: maps the analog stick or a ticked D-pad ramp onto an 8-bit thrust value.
// Optional analog slew limiting is compiled in with the THRUST_SLEW_EN macro.
module thrust_conditioner #(
  parameter int unsigned TICK_DIV   = 196850,
  parameter int unsigned THRUST_MAX = 254
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] analog_y,
  input  logic       dpad_up,
  input  logic       dpad_down,
  input  logic       dpad_mode,
  output logic [7:0] thrust,
  output logic       thrust_chg,
  output logic       state_dbg
);

  localparam logic [0:0]  ST_ANALOG = 1'b0;
  localparam logic [0:0]  ST_DPAD   = 1'b1;
  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [7:0]  MAX8      = 8'(THRUST_MAX);

  logic [19:0] tick_cnt;
  logic        tick;
  logic [0:0]  state;
  logic [7:0]  acc;
  logic [7:0]  acc_step;
  logic [8:0]  target_raw;
  logic [7:0]  target;
  logic [7:0]  thrust_nxt;

  assign tick      = (tick_cnt == TICK_LAST);
  assign state_dbg = state;

  // 127 - y with y sign-extended to 9 bits; the result always lies in 0..255.
  assign target_raw = 9'd127 - {analog_y[7], analog_y};
  assign target     = (target_raw > {1'b0, MAX8}) ? MAX8 : target_raw[7:0];

  always_comb begin
    acc_step = acc;
    if (tick && dpad_up && !dpad_down && (acc < MAX8)) begin
      acc_step = acc + 8'd1;
    end else if (tick && dpad_down && !dpad_up && (acc != 8'd0)) begin
      acc_step = acc - 8'd1;
    end
  end

  always_comb begin
    thrust_nxt = thrust;
    if (state == ST_DPAD) begin
      thrust_nxt = acc_step;
    end else begin
`ifdef THRUST_SLEW_EN
      if (tick) begin
        if (thrust < target) begin
          thrust_nxt = thrust + 8'd1;
        end else if (thrust > target) begin
          thrust_nxt = thrust - 8'd1;
        end
      end
`else
      thrust_nxt = target;
`endif
    end
  end

  // The accumulator always mirrors thrust, so entering DPAD starts from the current output.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      tick_cnt   <= 20'd0;
      state      <= ST_ANALOG;
      acc        <= 8'd0;
      thrust     <= 8'd0;
      thrust_chg <= 1'b0;
    end else begin
      tick_cnt   <= tick ? 20'd0 : tick_cnt + 20'd1;
      state      <= dpad_mode ? ST_DPAD : ST_ANALOG;
      acc        <= thrust_nxt;
      thrust     <= thrust_nxt;
      thrust_chg <= (thrust_nxt != thrust);
    end
  end

endmodule

// File: tb/tb_thrust_conditioner.sv
// Bench for thrust_conditioner: directed and random steps checked against a cycle reference model.
// Slew-limited expectations apply when THRUST_SLEW_EN is defined.
module tb_thrust_conditioner;

  localparam int TICK_DIV   = 4;
  localparam int THRUST_MAX = 254;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] analog_y = 8'h00;
  logic       dpad_up = 1'b0;
  logic       dpad_down = 1'b0;
  logic       dpad_mode = 1'b0;
  logic [7:0] thrust;
  logic       thrust_chg;
  logic       state_dbg;

  int errors = 0;
  int checks = 0;
  int chg_count = 0;

  // reference model state
  int m_thrust = 0;
  int m_cnt = 0;
  bit m_dpad = 1'b0;
  bit m_chg = 1'b0;

  always #10 clk_50 = ~clk_50;

  thrust_conditioner #(.TICK_DIV(TICK_DIV), .THRUST_MAX(THRUST_MAX)) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .analog_y  (analog_y),
    .dpad_up   (dpad_up),
    .dpad_down (dpad_down),
    .dpad_mode (dpad_mode),
    .thrust    (thrust),
    .thrust_chg(thrust_chg),
    .state_dbg (state_dbg)
  );

  function automatic int target_of(input logic [7:0] y);
    int t;
    t = 127 - int'($signed(y));
    return (t > THRUST_MAX) ? THRUST_MAX : t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  nxt;
    int  tgt;
    bit  tick;
    if (reset) begin
      m_thrust = 0;
      m_chg    = 1'b0;
      m_dpad   = 1'b0;
      m_cnt    = 0;
    end else begin
      tick  = (m_cnt == TICK_DIV - 1);
      m_cnt = (m_cnt + 1) % TICK_DIV;
      nxt   = m_thrust;
      tgt   = target_of(analog_y);
      if (m_dpad) begin
        if (tick && dpad_up && !dpad_down && m_thrust < THRUST_MAX) nxt = m_thrust + 1;
        else if (tick && dpad_down && !dpad_up && m_thrust > 0) nxt = m_thrust - 1;
      end else begin
`ifdef THRUST_SLEW_EN
        if (tick && tgt > nxt) nxt = nxt + 1;
        else if (tick && tgt < nxt) nxt = nxt - 1;
`else
        nxt = tgt;
`endif
      end
      m_chg    = (nxt != m_thrust);
      m_thrust = nxt;
      m_dpad   = dpad_mode;
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic step();
    @(posedge clk_50);
    model_edge();
    #1;
    check("thrust", 32'(thrust), 32'(m_thrust));
    check("thrust_chg", 32'(thrust_chg), 32'(m_chg));
    check("state", 32'(state_dbg), 32'(m_dpad));
    check("never_ff", 32'(thrust == 8'hFF), 32'd0);
    if (thrust_chg) chg_count++;
  endtask

  initial begin
    int n;
    logic [7:0] sweep_y [3];
    int         sweep_t [3];
    sweep_y = '{8'h7F, 8'h00, 8'h81};
    sweep_t = '{0, 127, 254};

    // reset held 3 cycles with full-forward stick
    reset    = 1'b1;
    analog_y = 8'h80;
    repeat (3) begin
      step();
      check("rst_thrust", 32'(thrust), 32'd0);
      check("rst_chg", 32'(thrust_chg), 32'd0);
    end
    reset     = 1'b0;
    chg_count = 0;
    step();
    step();
`ifndef THRUST_SLEW_EN
    check("release_thrust", 32'(thrust), 32'd254);
    check("release_pulses", 32'(chg_count), 32'd1);

    for (int i = 0; i < 3; i++) begin
      analog_y = sweep_y[i];
      step();
      check("sweep", 32'(thrust), 32'(sweep_t[i]));
    end
`endif

    // random analog stick
    repeat (40) begin
      analog_y = 8'($urandom_range(0, 255));
      step();
    end

    // bumpless switch at 127 then ramp up into saturation
    analog_y = 8'h00;
    repeat (1100) begin
      step();
      if (thrust == 8'd127) break;
    end
    dpad_mode = 1'b1;
    dpad_up   = 1'b1;
    chg_count = 0;
    repeat (600) step();
    check("ramp_sat", 32'(thrust), 32'd254);
    check("ramp_pulses", 32'(chg_count), 32'd127);

    // ramp down from 2 with both-held hold first
    dpad_up   = 1'b0;
    dpad_mode = 1'b0;
    analog_y  = 8'd125;
    repeat (1100) begin
      step();
      if (thrust == 8'd2 && !state_dbg) break;
    end
    check("at_two", 32'(thrust), 32'd2);
    dpad_mode = 1'b1;
    step();
    dpad_up   = 1'b1;
    dpad_down = 1'b1;
    repeat (12) step();
    check("both_hold", 32'(thrust), 32'd2);
    dpad_up = 1'b0;
    repeat (20) step();
    check("floor_zero", 32'(thrust), 32'd0);
    dpad_down = 1'b0;

    // random D-pad activity with occasional mode flips
    repeat (300) begin
      if ($urandom_range(0, 7) == 0) begin
        dpad_up   = 1'($urandom_range(0, 1));
        dpad_down = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) dpad_mode = ~dpad_mode;
      if ($urandom_range(0, 9) == 0) analog_y = 8'($urandom_range(0, 255));
      step();
    end

    // mid-period reset from 50 in DPAD
    dpad_up   = 1'b0;
    dpad_down = 1'b0;
    dpad_mode = 1'b0;
    analog_y  = 8'd77;
    repeat (1100) begin
      step();
      if (thrust == 8'd50 && !state_dbg) break;
    end
    check("at_fifty", 32'(thrust), 32'd50);
    dpad_mode = 1'b1;
    repeat (2 + $urandom_range(0, 3)) step();
    reset = 1'b1;
    step();
    check("reset_thrust", 32'(thrust), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset    = 1'b0;
    analog_y = 8'h7F;
    dpad_up  = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (thrust == 8'd0 && n < 20);
    check("first_tick", 32'(n), 32'd4);
    dpad_up   = 1'b0;
    dpad_mode = 1'b0;

`ifdef THRUST_SLEW_EN
    // slew from 0 to full forward
    analog_y = 8'h7F;
    repeat (1100) begin
      step();
      if (thrust == 8'd0 && !state_dbg) break;
    end
    chg_count = 0;
    analog_y  = 8'h80;
    n = 0;
    do begin
      step();
      n++;
    end while (thrust != 8'd254 && n < 1100);
    check("slew_pulses", 32'(chg_count), 32'd254);
    check("slew_time_ok", 32'(n >= 1013 && n <= 1016), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
